// File: rtl/_demux32_buf_pkg.sv
// Shared definitions for the two-channel word demultiplexer: select encodings
// and the pointer/occupancy width helpers used by the per-channel FIFOs.
package _demux32_buf_pkg;

    localparam logic DEMUX_SEL_A = 1'b0;
    localparam logic DEMUX_SEL_B = 1'b1;

    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy must reach DEPTH itself, hence DEPTH+1 states.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/_demux32_buf_if.sv
// Source and two sink handshake bundles of the word demultiplexer.
// master = the environment (source + sinks), slave = the demux itself.
interface _demux32_buf_if
    import _demux32_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
);
    localparam int CW = cnt_w(DEPTH);

    logic [WIDTH-1:0] in_data;
    logic             in_sel;
    logic             in_valid;
    logic             in_ready;

    logic [WIDTH-1:0] a_data;
    logic             a_valid;
    logic             a_ready;
    logic [CW-1:0]    a_count;

    logic [WIDTH-1:0] b_data;
    logic             b_valid;
    logic             b_ready;
    logic [CW-1:0]    b_count;

    modport master (
        output in_data, in_sel, in_valid, a_ready, b_ready,
        input  in_ready, a_data, a_valid, a_count, b_data, b_valid, b_count
    );

    modport slave (
        input  in_data, in_sel, in_valid, a_ready, b_ready,
        output in_ready, a_data, a_valid, a_count, b_data, b_valid, b_count
    );

endinterface

// File: rtl/_demux32_buf_fifo.sv
// Small per-channel FIFO: registered storage, wrapping pointers, explicit
// occupancy count; the head word is read combinationally from storage.
module _demux_fifo
    import _demux32_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    push,
    input  logic                    pop,
    input  logic [WIDTH-1:0]        wdata,
    output logic                    full,
    output logic                    empty,
    output logic [cnt_w(DEPTH)-1:0] count,
    output logic [WIDTH-1:0]        head
);
    localparam int              PW       = ptr_w(DEPTH);
    localparam int              CW       = cnt_w(DEPTH);
    localparam logic [CW-1:0]   FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // A pop on an empty FIFO is dropped, so push+pop while empty just lands the push.
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/_demux32_buf.sv
// Steers one source word onto channel A or B; each channel buffers in its
// own FIFO so a stalled sink never blocks the other one.
module _demux32_buf
    import _demux32_buf_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input logic            clk,
    input logic            rst_n,
    _demux32_buf_if.slave  bus
);
    logic full_a, full_b;
    logic empty_a, empty_b;
    logic push_a, push_b;

    // Ready comes from registered fullness only, never from the sink readies.
    assign bus.in_ready = (bus.in_sel == DEMUX_SEL_B) ? ~full_b : ~full_a;
    assign push_a       = bus.in_valid & bus.in_ready & (bus.in_sel == DEMUX_SEL_A);
    assign push_b       = bus.in_valid & bus.in_ready & (bus.in_sel == DEMUX_SEL_B);
    assign bus.a_valid  = ~empty_a;
    assign bus.b_valid  = ~empty_b;

    _demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_a (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_a),
        .pop   (bus.a_ready),
        .wdata (bus.in_data),
        .full  (full_a),
        .empty (empty_a),
        .count (bus.a_count),
        .head  (bus.a_data)
    );

    _demux_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo_b (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_b),
        .pop   (bus.b_ready),
        .wdata (bus.in_data),
        .full  (full_b),
        .empty (empty_b),
        .count (bus.b_count),
        .head  (bus.b_data)
    );

endmodule
